wordle_game_ctrl: RTL and testbench
===================================

Name: wordle_game_ctrl

Overview:
Parametrised Wordle game controller and the successor to the fixed 5-letter, 6-guess state machine.
- Word length and guess budget are set by parameters.
- Keyboard entry is buffered with backspace and an explicit enter.
- Each submitted guess is scored per letter (green/yellow/gray) with correct duplicate-letter handling.
- Sits between the keyboard decoder and the display/top-level; the target word is supplied externally, from the LFSR word-select logic.

Parameters:
WORD_LEN, 5, letters per word (2..8)
MAX_GUESSES, 6, guesses allowed before loss (1..15)

Ports:
Clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a new game, samples target_word
target_word  input  8*WORD_LEN  ASCII target; position 0 in bits [7:0]
letter_valid  input  1  letter strobe from keyboard
letter  input  8  ASCII letter
backspace  input  1  delete-last-letter strobe
enter  input  1  submit-guess strobe
guess_buf  output  8*WORD_LEN  current entry buffer; position 0 in bits [7:0]
letter_idx  output  $clog2(WORD_LEN+1)  letters currently in the buffer
guess_num  output  $clog2(MAX_GUESSES+1)  guesses already scored
score  output  2*WORD_LEN  per-position result; position 0 in bits [1:0]; 00 gray, 01 yellow, 10 green
score_valid  output  1  one-cycle pulse when score updates
enter_reject  output  1  one-cycle pulse: enter with buffer not full
busy  output  1  high in SCORE_G/SCORE_Y/REPORT
win  output  1  level; DONE and last guess all green
lose  output  1  level; DONE and not win

Behaviour:
- Reset (synchronous): state IDLE; target register, guess_buf, letter_idx, guess_num and score all 0; every pulse output, win and lose are 0.
- States: IDLE, ENTRY, SCORE_G, SCORE_Y, REPORT, DONE.
- IDLE / DONE: start → latch target_word, clear guess_buf/letter_idx/guess_num/score → ENTRY. win/lose hold in DONE until start.
- start in any other state is ignored.
- ENTRY: one input action per cycle, priority enter > backspace > letter_valid.
  - letter: accepted only if letter_idx < WORD_LEN and letter is in 'A'..'Z'. It is written to slot letter_idx and letter_idx increments. Otherwise ignored; no state change.
  - backspace: if letter_idx > 0, decrement and clear that slot to 0. At 0, ignored.
  - enter: if letter_idx == WORD_LEN → SCORE_G. Otherwise enter_reject pulses for one cycle and the buffer is unchanged.
- Scoring latency: enter accepted at edge t gives the following sequence.
  - SCORE_G for 1 cycle: all positions compared in parallel; matches marked green, and the corresponding target slots marked used.
  - SCORE_Y for WORD_LEN cycles, one guess position i per cycle in ascending order. A non-green i is marked yellow at the lowest-index unused target slot j with target[j]==guess[i], and j is then marked used. If no such slot exists, i is gray.
  - REPORT at edge t+WORD_LEN+2: score, incremented guess_num and score_valid are all visible.
- REPORT exit: all green or guess_num == MAX_GUESSES → DONE; else → ENTRY with guess_buf and letter_idx cleared.
- Inputs arriving while busy are dropped; no queuing.
- score holds its value until the next REPORT or start.
- Reset mid-scoring aborts scoring and returns to IDLE with all outputs at their reset values.
- Counters never wrap; guess_num saturates at MAX_GUESSES by construction.

Decomposition:
- wordle_pkg: state encoding, score codes (GRAY/YELLOW/GREEN), ASCII 'A'/'Z' constants.
- One sub-module, wordle_scorer: holds the target/used masks, the green pass and the iterative yellow pass. It takes a start pulse plus guess/target, and returns a done pulse plus score.
- The controller owns entry buffering, counters and game state.

Test Plan:
1. target "ROBOT", type B,O,O,S,T, enter → score_valid exactly 7 cycles later; score positions 0..4 = Y,G,Y,X,G; guess_num 1; returns to ENTRY.
2. target "ABBOT", guess "BABBB" → positions Y,Y,G,X,X (duplicate B gray once the target Bs are used).
3. type "CRI", enter → enter_reject pulse, letter_idx stays 3. Backspace ×4 → letter_idx 0, then the 4th backspace is ignored. A 6th letter after 5 are typed is ignored. Lowercase 'a' is ignored.
4. target "WALTZ", guesses "RENEW" then "WALTZ" → second REPORT all green, DONE, win=1, guess_num=2. Keyboard input is then ignored; start → ENTRY with the new target.
5. MAX_GUESSES=6 with six wrong guesses → DONE after the 6th REPORT, lose=1, win=0.
6. WORD_LEN=3, MAX_GUESSES=2 build; reset asserted during SCORE_Y → next cycle IDLE, score=0, busy=0, score_valid never pulses.

Source files
------------

// File: rtl/wordle_pkg.sv
// wordle_pkg: shared state encoding, per-letter score codes and ASCII bounds
// for the Wordle game controller and its scorer.
package wordle_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        SCORE_G = 3'd2,
        SCORE_Y = 3'd3,
        REPORT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] GRAY   = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;

endpackage

// File: rtl/wordle_game_ctrl_scorer.sv
// wordle_scorer: scores one guess against the target. A start pulse runs the
// parallel green pass; the yellow pass then walks the guess one position per
// cycle so that duplicate letters claim target slots lowest-index first.
module wordle_scorer #(
    parameter int WORD_LEN = 5
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*WORD_LEN-1:0] guess,
    input  logic [8*WORD_LEN-1:0] target,
    output logic                  done,
    output logic [2*WORD_LEN-1:0] score
);
    import wordle_pkg::*;

    localparam int IW = $clog2(WORD_LEN);

    logic [8*WORD_LEN-1:0] guess_q;
    logic [8*WORD_LEN-1:0] target_q;
    logic [WORD_LEN-1:0]   used_q;
    logic [WORD_LEN-1:0]   used_next;
    logic [IW-1:0]         idx_q;
    logic                  active_q;
    logic [7:0]            cur_letter;
    logic [1:0]            cur_code;
    logic                  found;

    // Yellow search for the current position: lowest unused matching target slot
    always_comb begin
        cur_letter = '0;
        cur_code   = GRAY;
        found      = 1'b0;
        used_next  = used_q;
        for (int k = 0; k < WORD_LEN; k++) begin
            if (IW'(k) == idx_q) begin
                cur_letter = guess_q[8*k +: 8];
                cur_code   = score[2*k +: 2];
            end
        end
        if (cur_code != GREEN) begin
            for (int j = 0; j < WORD_LEN; j++) begin
                if (!found && !used_q[j] && target_q[8*j +: 8] == cur_letter) begin
                    found        = 1'b1;
                    used_next[j] = 1'b1;
                end
            end
        end
    end

    // Green pass on start, then one yellow step per cycle until the last position
    always_ff @(posedge Clk) begin
        if (reset) begin
            guess_q  <= '0;
            target_q <= '0;
            used_q   <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
            done     <= 1'b0;
            score    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                guess_q  <= guess;
                target_q <= target;
                idx_q    <= '0;
                active_q <= 1'b1;
                for (int k = 0; k < WORD_LEN; k++) begin
                    if (guess[8*k +: 8] == target[8*k +: 8]) begin
                        score[2*k +: 2] <= GREEN;
                        used_q[k]       <= 1'b1;
                    end else begin
                        score[2*k +: 2] <= GRAY;
                        used_q[k]       <= 1'b0;
                    end
                end
            end else if (active_q) begin
                used_q <= used_next;
                for (int k = 0; k < WORD_LEN; k++) begin
                    if (found && IW'(k) == idx_q) begin
                        score[2*k +: 2] <= YELLOW;
                    end
                end
                if (idx_q == IW'(WORD_LEN - 1)) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wordle_game_ctrl.sv
// wordle_game_ctrl: keyboard entry buffer, guess counter and game state for a
// parametrised Wordle round; per-letter scoring is delegated to wordle_scorer.
//
// state   | meaning
// IDLE    | no game in progress, waiting for start
// ENTRY   | collecting letters, backspace and enter
// SCORE_G | scorer running its parallel green pass
// SCORE_Y | scorer walking positions for yellows
// REPORT  | score and guess count just updated
// DONE    | game over, win/lose held until start
module wordle_game_ctrl #(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6
) (
    input  logic                               Clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [8*WORD_LEN-1:0]              target_word,
    input  logic                               letter_valid,
    input  logic [7:0]                         letter,
    input  logic                               backspace,
    input  logic                               enter,
    output logic [8*WORD_LEN-1:0]              guess_buf,
    output logic [$clog2(WORD_LEN+1)-1:0]      letter_idx,
    output logic [$clog2(MAX_GUESSES+1)-1:0]   guess_num,
    output logic [2*WORD_LEN-1:0]              score,
    output logic                               score_valid,
    output logic                               enter_reject,
    output logic                               busy,
    output logic                               win,
    output logic                               lose
);
    import wordle_pkg::*;

    localparam int LI_W = $clog2(WORD_LEN + 1);
    localparam int GN_W = $clog2(MAX_GUESSES + 1);
    localparam logic [LI_W-1:0]       LI_FULL   = LI_W'(WORD_LEN);
    localparam logic [GN_W-1:0]       GN_MAX    = GN_W'(MAX_GUESSES);
    localparam logic [2*WORD_LEN-1:0] ALL_GREEN = {WORD_LEN{GREEN}};

    state_t                state_q, state_d;
    logic [8*WORD_LEN-1:0] target_q;
    logic                  load_game, add_letter, del_letter, reject;
    logic                  scorer_start, report_load, next_round;
    logic                  letter_ok;
    logic                  sc_done;
    logic [2*WORD_LEN-1:0] sc_score;

    assign letter_ok = (letter >= ASCII_A) && (letter <= ASCII_Z);
    assign busy      = (state_q == SCORE_G) || (state_q == SCORE_Y) || (state_q == REPORT);
    assign win       = (state_q == DONE) && (score == ALL_GREEN);
    assign lose      = (state_q == DONE) && (score != ALL_GREEN);

    wordle_scorer #(.WORD_LEN(WORD_LEN)) u_scorer (
        .Clk    (Clk),
        .reset  (reset),
        .start  (scorer_start),
        .guess  (guess_buf),
        .target (target_q),
        .done   (sc_done),
        .score  (sc_score)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and one-cycle control strobes; enter beats backspace beats letter
    always_comb begin
        state_d      = state_q;
        load_game    = 1'b0;
        add_letter   = 1'b0;
        del_letter   = 1'b0;
        reject       = 1'b0;
        scorer_start = 1'b0;
        report_load  = 1'b0;
        next_round   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load_game = 1'b1;
                    state_d   = ENTRY;
                end
            end
            ENTRY: begin
                if (enter) begin
                    if (letter_idx == LI_FULL) state_d = SCORE_G;
                    else                       reject  = 1'b1;
                end else if (backspace) begin
                    del_letter = (letter_idx != '0);
                end else if (letter_valid) begin
                    add_letter = letter_ok && (letter_idx < LI_FULL);
                end
            end
            SCORE_G: begin
                scorer_start = 1'b1;
                state_d      = SCORE_Y;
            end
            SCORE_Y: begin
                if (sc_done) begin
                    report_load = 1'b1;
                    state_d     = REPORT;
                end
            end
            REPORT: begin
                if (score == ALL_GREEN || guess_num == GN_MAX) begin
                    state_d = DONE;
                end else begin
                    next_round = 1'b1;
                    state_d    = ENTRY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry buffer, target latch, counters and result registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            target_q     <= '0;
            guess_buf    <= '0;
            letter_idx   <= '0;
            guess_num    <= '0;
            score        <= '0;
            score_valid  <= 1'b0;
            enter_reject <= 1'b0;
        end else begin
            score_valid  <= report_load;
            enter_reject <= reject;
            if (load_game) begin
                target_q   <= target_word;
                guess_buf  <= '0;
                letter_idx <= '0;
                guess_num  <= '0;
                score      <= '0;
            end else if (add_letter) begin
                for (int k = 0; k < WORD_LEN; k++) begin
                    if (LI_W'(k) == letter_idx) guess_buf[8*k +: 8] <= letter;
                end
                letter_idx <= letter_idx + 1'b1;
            end else if (del_letter) begin
                for (int k = 0; k < WORD_LEN; k++) begin
                    if (LI_W'(k + 1) == letter_idx) guess_buf[8*k +: 8] <= '0;
                end
                letter_idx <= letter_idx - 1'b1;
            end else if (report_load) begin
                score     <= sc_score;
                guess_num <= guess_num + 1'b1;
            end else if (next_round) begin
                guess_buf  <= '0;
                letter_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wordle_game_ctrl.sv
// tb_wordle_game_ctrl: scenario tasks for the default 5x6 build plus a 3x2 build,
// with scores checked against a letter-count Wordle reference model.
module tb_wordle_game_ctrl;

    localparam int WL = 5, MG = 6, WLS = 3, MGS = 2;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    logic          reset, start, letter_valid, backspace, enter;
    logic [7:0]    letter;
    logic [39:0]   target_word, guess_buf;
    logic [2:0]    letter_idx, guess_num;
    logic [9:0]    score;
    logic          score_valid, enter_reject, busy, win, lose;

    logic          reset_s, start_s, letter_valid_s, backspace_s, enter_s;
    logic [7:0]    letter_s;
    logic [23:0]   target_word_s, guess_buf_s;
    logic [1:0]    letter_idx_s, guess_num_s;
    logic [5:0]    score_s;
    logic          score_valid_s, enter_reject_s, busy_s, win_s, lose_s;

    wordle_game_ctrl #(.WORD_LEN(WL), .MAX_GUESSES(MG)) dut (
        .Clk(Clk), .reset(reset), .start(start), .target_word(target_word),
        .letter_valid(letter_valid), .letter(letter), .backspace(backspace), .enter(enter),
        .guess_buf(guess_buf), .letter_idx(letter_idx), .guess_num(guess_num), .score(score),
        .score_valid(score_valid), .enter_reject(enter_reject), .busy(busy), .win(win), .lose(lose)
    );

    wordle_game_ctrl #(.WORD_LEN(WLS), .MAX_GUESSES(MGS)) dut_s (
        .Clk(Clk), .reset(reset_s), .start(start_s), .target_word(target_word_s),
        .letter_valid(letter_valid_s), .letter(letter_s), .backspace(backspace_s), .enter(enter_s),
        .guess_buf(guess_buf_s), .letter_idx(letter_idx_s), .guess_num(guess_num_s), .score(score_s),
        .score_valid(score_valid_s), .enter_reject(enter_reject_s), .busy(busy_s), .win(win_s), .lose(lose_s)
    );

    // Reference: greens first, then yellows consume remaining target letter counts left to right
    function automatic logic [15:0] ref_score(input logic [63:0] t, input logic [63:0] g, input int n);
        int         cnt[26];
        logic [15:0] r;
        logic [7:0]  tc, gc;
        r = '0;
        foreach (cnt[k]) cnt[k] = 0;
        for (int i = 0; i < n; i++) begin
            tc = t[8*i +: 8];
            gc = g[8*i +: 8];
            if (tc == gc) r[2*i +: 2] = 2'b10;
            else          cnt[int'(tc) - 65]++;
        end
        for (int i = 0; i < n; i++) begin
            gc = g[8*i +: 8];
            if (r[2*i +: 2] != 2'b10 && cnt[int'(gc) - 65] > 0) begin
                r[2*i +: 2] = 2'b01;
                cnt[int'(gc) - 65]--;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] wd(input string s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [63:0] rand_word(input int n, input int alpha);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = 8'(65 + int'($urandom_range(alpha - 1)));
        return r;
    endfunction

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [39:0] w);
        target_word = w;
        start = 1'b1;
        cyc();
        start = 1'b0;
        target_word = '0;
    endtask

    task automatic press_letter(input logic [7:0] c);
        letter_valid = 1'b1;
        letter = c;
        cyc();
        letter_valid = 1'b0;
        letter = '0;
    endtask

    task automatic press_bs();
        backspace = 1'b1;
        cyc();
        backspace = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        cyc();
        enter = 1'b0;
    endtask

    task automatic wait_report(output int lat);
        lat = 0;
        do begin
            cyc();
            lat++;
        end while (!score_valid && lat < 40);
    endtask

    task automatic submit(input logic [39:0] w, output int lat);
        for (int i = 0; i < WL; i++) press_letter(w[8*i +: 8]);
        press_enter();
        wait_report(lat);
    endtask

    task automatic small_submit(input logic [23:0] w, output int lat);
        for (int i = 0; i < WLS; i++) begin
            letter_valid_s = 1'b1;
            letter_s = w[8*i +: 8];
            cyc();
        end
        letter_valid_s = 1'b0;
        enter_s = 1'b1;
        cyc();
        enter_s = 1'b0;
        lat = 0;
        do begin
            cyc();
            lat++;
        end while (!score_valid_s && lat < 40);
    endtask

    task automatic test_reset();
        do_reset();
        do_start(40'h4142434445);
        press_letter("Q");
        press_letter("R");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total++; if (guess_buf !== '0) begin bad++; $display("FAIL reset_guess_buf got=%h want=0", guess_buf); end
        total++; if (letter_idx !== '0) begin bad++; $display("FAIL reset_letter_idx got=%0d want=0", letter_idx); end
        total++; if ({guess_num, score} !== '0) begin bad++; $display("FAIL reset_counts got=%h want=0", {guess_num, score}); end
        total++; if ({score_valid, enter_reject, busy, win, lose} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {score_valid, enter_reject, busy, win, lose}); end
        press_letter("Q");
        total++; if (letter_idx !== '0) begin bad++; $display("FAIL idle_ignores_letter got=%0d want=0", letter_idx); end
    endtask

    task automatic test_scoring_examples();
        int          lat;
        logic [15:0] exp;
        do_reset();
        do_start(wd("ROBOT"));
        for (int i = 0; i < WL; i++) press_letter(wd("BOOST") >> (8*i));
        total++; if (guess_buf !== wd("BOOST")) begin bad++; $display("FAIL buf_boost got=%h want=%h", guess_buf, wd("BOOST")); end
        press_enter();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_enter got=%b want=1", busy); end
        wait_report(lat);
        exp = ref_score(wd("ROBOT"), wd("BOOST"), WL);
        total++; if (lat !== 7) begin bad++; $display("FAIL robot_latency got=%0d want=7", lat); end
        total++; if (score !== 10'b1000011001) begin bad++; $display("FAIL robot_score got=%b want=1000011001", score); end
        total++; if (score !== exp[9:0]) begin bad++; $display("FAIL robot_model got=%b want=%b", score, exp[9:0]); end
        total++; if (guess_num !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL robot_report got=%0d/%b want=1/1", guess_num, busy); end
        cyc();
        total++; if ({score_valid, busy, letter_idx} !== 5'b0 || guess_buf !== '0) begin bad++; $display("FAIL robot_back_to_entry got=%b/%0d/%h want=0/0/0", {score_valid, busy}, letter_idx, guess_buf); end
        total++; if (score !== 10'b1000011001) begin bad++; $display("FAIL robot_score_hold got=%b want=1000011001", score); end
        do_reset();
        do_start(wd("ABBOT"));
        submit(wd("BABBB"), lat);
        total++; if (score !== 10'b0000100101) begin bad++; $display("FAIL abbot_score got=%b want=0000100101", score); end
    endtask

    task automatic test_entry();
        do_reset();
        do_start(wd("CRANE"));
        press_letter("C"); press_letter("R"); press_letter("I");
        press_enter();
        total++; if (enter_reject !== 1'b1 || letter_idx !== 3'd3) begin bad++; $display("FAIL reject_pulse got=%b/%0d want=1/3", enter_reject, letter_idx); end
        total++; if (guess_buf !== wd("CRI")) begin bad++; $display("FAIL reject_buf got=%h want=%h", guess_buf, wd("CRI")); end
        cyc();
        total++; if (enter_reject !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reject_one_cycle got=%b/%b want=0/0", enter_reject, busy); end
        enter = 1'b1; letter_valid = 1'b1; letter = "X";
        cyc();
        enter = 1'b0; backspace = 1'b1;
        cyc();
        backspace = 1'b0; letter_valid = 1'b0;
        total++; if (letter_idx !== 3'd2 || guess_buf !== wd("CR")) begin bad++; $display("FAIL priority got=%0d/%h want=2/%h", letter_idx, guess_buf, wd("CR")); end
        press_bs(); press_bs();
        total++; if (letter_idx !== 3'd0 || guess_buf !== '0) begin bad++; $display("FAIL bs_to_zero got=%0d/%h want=0/0", letter_idx, guess_buf); end
        press_bs();
        press_letter("a"); press_letter(8'h40); press_letter(8'h5B);
        total++; if (letter_idx !== 3'd0) begin bad++; $display("FAIL bad_letters got=%0d want=0", letter_idx); end
        press_letter("A"); press_letter("Z");
        total++; if (letter_idx !== 3'd2 || guess_buf !== wd("AZ")) begin bad++; $display("FAIL edge_letters got=%0d/%h want=2/%h", letter_idx, guess_buf, wd("AZ")); end
        press_bs(); press_bs();
        for (int i = 0; i < WL; i++) press_letter(wd("HELLO") >> (8*i));
        press_letter("X");
        total++; if (letter_idx !== 3'd5 || guess_buf !== wd("HELLO")) begin bad++; $display("FAIL sixth_letter got=%0d/%h want=5/%h", letter_idx, guess_buf, wd("HELLO")); end
    endtask

    task automatic test_win();
        int          lat;
        logic [15:0] exp;
        do_reset();
        do_start(wd("WALTZ"));
        submit(wd("RENEW"), lat);
        exp = ref_score(wd("WALTZ"), wd("RENEW"), WL);
        total++; if (score !== exp[9:0]) begin bad++; $display("FAIL renew_score got=%b want=%b", score, exp[9:0]); end
        cyc();
        submit(wd("WALTZ"), lat);
        total++; if (score !== 10'b1010101010 || guess_num !== 3'd2) begin bad++; $display("FAIL waltz_report got=%b/%0d want=1010101010/2", score, guess_num); end
        cyc();
        total++; if ({win, lose, busy} !== 3'b100) begin bad++; $display("FAIL waltz_done got=%b want=100", {win, lose, busy}); end
        press_bs(); press_letter("Q"); press_enter();
        total++; if (letter_idx !== 3'd5 || enter_reject !== 1'b0 || win !== 1'b1) begin bad++; $display("FAIL done_ignores_keys got=%0d/%b/%b want=5/0/1", letter_idx, enter_reject, win); end
        do_start(wd("PLUMB"));
        total++; if ({win, lose, guess_num, score, letter_idx} !== '0) begin bad++; $display("FAIL restart_clear got=%b/%0d/%b/%0d want=0", {win, lose}, guess_num, score, letter_idx); end
        submit(wd("PLUMB"), lat);
        total++; if (score !== 10'b1010101010) begin bad++; $display("FAIL new_target got=%b want=1010101010", score); end
    endtask

    task automatic test_lose();
        int          lat;
        logic [63:0] rt, rg;
        logic [15:0] exp;
        do_reset();
        rt = rand_word(WL, 26);
        do_start(rt[39:0]);
        for (int g = 0; g < MG; g++) begin
            do rg = rand_word(WL, 26); while (rg == rt);
            submit(rg[39:0], lat);
            exp = ref_score(rt, rg, WL);
            total++; if (score !== exp[9:0] || guess_num !== 3'(g + 1)) begin bad++; $display("FAIL lose_guess%0d got=%b/%0d want=%b/%0d", g, score, guess_num, exp[9:0], g + 1); end
            cyc();
            if (g < MG - 1) begin
                total++; if ({win, lose, busy} !== 3'b000) begin bad++; $display("FAIL lose_midgame%0d got=%b want=000", g, {win, lose, busy}); end
            end
        end
        total++; if ({win, lose} !== 2'b01) begin bad++; $display("FAIL lose_final got=%b want=01", {win, lose}); end
    endtask

    task automatic test_random();
        int          lat;
        logic [63:0] rt, rg;
        logic [15:0] exp;
        logic        won;
        do_reset();
        for (int gm = 0; gm < 8; gm++) begin
            rt = rand_word(WL, 3);
            do_start(rt[39:0]);
            won = 1'b0;
            for (int g = 0; g < MG && !won; g++) begin
                rg = rand_word(WL, 3);
                submit(rg[39:0], lat);
                exp = ref_score(rt, rg, WL);
                total++; if (score !== exp[9:0] || lat !== 7 || guess_num !== 3'(g + 1)) begin bad++; $display("FAIL rand_g%0d_%0d got=%b/%0d/%0d want=%b/7/%0d", gm, g, score, lat, guess_num, exp[9:0], g + 1); end
                won = (exp[9:0] == 10'b1010101010);
                cyc();
            end
            total++; if ({win, lose} !== {won, !won}) begin bad++; $display("FAIL rand_end%0d got=%b want=%b", gm, {win, lose}, {won, !won}); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_reset();
        do_start(wd("MANGO"));
        for (int i = 0; i < WL; i++) press_letter(wd("STEAM") >> (8*i));
        press_enter();
        press_letter("A");
        target_word = wd("ZZZZZ"); start = 1'b1;
        cyc();
        start = 1'b0; target_word = '0;
        press_bs(); press_enter();
        wait_report(lat);
        cyc();
        total++; if (letter_idx !== 3'd0 || guess_buf !== '0 || guess_num !== 3'd1) begin bad++; $display("FAIL busy_drop got=%0d/%h/%0d want=0/0/1", letter_idx, guess_buf, guess_num); end
        submit(wd("MANGO"), lat);
        total++; if (score !== 10'b1010101010 || lat !== 7) begin bad++; $display("FAIL start_ignored got=%b/%0d want=1010101010/7", score, lat); end
    endtask

    task automatic test_small_build();
        int          lat, seen;
        logic [15:0] exp;
        reset_s = 1'b1; cyc(); reset_s = 1'b0;
        target_word_s = wd("CAT"); start_s = 1'b1; cyc(); start_s = 1'b0;
        small_submit(wd("TAC"), lat);
        exp = ref_score(wd("CAT"), wd("TAC"), WLS);
        total++; if (score_s !== exp[5:0] || lat !== 5) begin bad++; $display("FAIL small_score got=%b/%0d want=%b/5", score_s, lat, exp[5:0]); end
        cyc();
        for (int i = 0; i < WLS; i++) begin
            letter_valid_s = 1'b1; letter_s = wd("DOG") >> (8*i); cyc();
        end
        letter_valid_s = 1'b0;
        enter_s = 1'b1; cyc(); enter_s = 1'b0;
        cyc(); cyc();
        total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL small_in_scoring got=%b want=1", busy_s); end
        reset_s = 1'b1; cyc(); reset_s = 1'b0;
        total++; if ({busy_s, score_valid_s, win_s, lose_s} !== 4'b0 || score_s !== '0 || guess_num_s !== '0) begin bad++; $display("FAIL small_abort got=%b/%b/%0d want=0/0/0", {busy_s, score_valid_s}, score_s, guess_num_s); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (score_valid_s) seen++;
            cyc();
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL small_no_valid got=%0d want=0", seen); end
        start_s = 1'b1; cyc(); start_s = 1'b0;
        small_submit(wd("DOG"), lat);
        cyc();
        small_submit(wd("DOG"), lat);
        total++; if (guess_num_s !== 2'd2) begin bad++; $display("FAIL small_guess_num got=%0d want=2", guess_num_s); end
        cyc();
        total++; if ({win_s, lose_s} !== 2'b01) begin bad++; $display("FAIL small_lose got=%b want=01", {win_s, lose_s}); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; target_word = '0; letter_valid = 1'b0; letter = '0;
        backspace = 1'b0; enter = 1'b0;
        reset_s = 1'b1; start_s = 1'b0; target_word_s = '0; letter_valid_s = 1'b0; letter_s = '0;
        backspace_s = 1'b0; enter_s = 1'b0;
        cyc();
        test_reset();
        test_scoring_examples();
        test_entry();
        test_win();
        test_lose();
        test_random();
        test_back_to_back();
        test_small_build();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
